// File: rtl/g18_flash_responder.sv
// g18_flash_responder: device-side model of the G18 parallel NOR flash bus, backed by on-chip RAM.
// Supports array read, status, ID and word-program commands with busy timing and a
// programmable read latency.
// Optional build macro G18_RESP_LOCK_EN adds per-64-word-block lock bits (commands 60/01, 60/D0).
module g18_flash_responder #(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned READ_LAT    = 3,
  parameter int unsigned PROG_CYCLES = 16,
  parameter logic [15:0] MFR_ID      = 16'h0089,
  parameter logic [15:0] DEV_ID      = 16'h8960
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic [24:0] g18_adr_i,
  input  logic        g18_csn_i,
  input  logic        g18_oen_i,
  input  logic        g18_wen_i,
  input  logic        g18_advn_i,
  input  logic [15:0] g18_dat_i,
  output logic [15:0] g18_dat_o,
  output logic        g18_dat_oe_o,
  output logic        busy_o
);

  localparam int unsigned Words = 1 << MEM_AW;

  typedef enum logic [2:0] {
    ModeArray,
    ModeStatus,
    ModeId,
    ModeProgSetup,
    ModeProgBusy,
    ModeLockSetup
  } mode_e;

  mode_e             mode_q;
  logic [7:0]        status_q;
  logic              busy_q;
  logic [7:0]        prog_cnt_q;
  logic [MEM_AW-1:0] prog_adr_q;
  logic [15:0]       prog_dat_q;

  logic [MEM_AW-1:0] adr_lat_q;
  logic [MEM_AW-1:0] eff_adr;
  logic              adv;

  logic              wen_q;
  logic [15:0]       wr_dat_q;
  logic [MEM_AW-1:0] wr_adr_q;
  logic              wr_strobe;
  logic [7:0]        cmd;

  logic              read_act;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [MEM_AW-1:0] rd_adr_q;
  logic [15:0]       dat_q, dat_d;
  logic              dat_oe_q;
  logic [15:0]       rd_word;

  // Array is stored bit-inverted so that the all-zero power-up state reads as erased 16'hFFFF.
  logic [15:0]       mem_inv_q [Words];
  logic [15:0]       ram_word;
  logic [15:0]       prog_old;
  logic [15:0]       prog_new;
  logic              prog_last;

  logic unused_adr;
  assign unused_adr = ^g18_adr_i[24:MEM_AW];

`ifdef G18_RESP_LOCK_EN
  localparam int unsigned Blocks = 1 << (MEM_AW - 6);
  logic [Blocks-1:0] lock_q;
`endif

  assign adv       = ~g18_csn_i & ~g18_advn_i;
  assign eff_adr   = adv ? g18_adr_i[MEM_AW-1:0] : adr_lat_q;
  assign wr_strobe = ~g18_csn_i & ~wen_q & g18_wen_i;
  assign cmd       = wr_dat_q[7:0];
  assign read_act  = ~g18_csn_i & ~g18_oen_i & g18_wen_i;

  assign ram_word  = ~mem_inv_q[eff_adr];
  assign prog_old  = ~mem_inv_q[prog_adr_q];
  assign prog_new  = prog_old & prog_dat_q;
  assign prog_last = (mode_q == ModeProgBusy) && (prog_cnt_q == 8'(PROG_CYCLES - 1));

  // Address latch plus one-cycle history of wen/data/address used by the write strobe.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      adr_lat_q <= '0;
      wen_q     <= 1'b1;
      wr_dat_q  <= '0;
      wr_adr_q  <= '0;
    end else begin
      if (adv) adr_lat_q <= g18_adr_i[MEM_AW-1:0];
      wen_q    <= g18_wen_i;
      wr_dat_q <= g18_dat_i;
      wr_adr_q <= eff_adr;
    end
  end

  // Array write on the last busy cycle; a reset in that cycle aborts the program.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_n_i && prog_last) mem_inv_q[prog_adr_q] <= ~prog_new;
  end

  // Command FSM: mode, status register, program timer and lock bits.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      mode_q     <= ModeArray;
      status_q   <= 8'h80;
      busy_q     <= 1'b0;
      prog_cnt_q <= '0;
      prog_adr_q <= '0;
      prog_dat_q <= '0;
`ifdef G18_RESP_LOCK_EN
      lock_q     <= '1;
`endif
    end else begin
      case (mode_q)
        ModeArray, ModeStatus, ModeId: begin
          if (wr_strobe) begin
            case (cmd)
              8'hFF: mode_q <= ModeArray;
              8'h70: mode_q <= ModeStatus;
              8'h90: mode_q <= ModeId;
              8'h50: begin
                status_q[4] <= 1'b0;
                status_q[1] <= 1'b0;
              end
              8'h40, 8'h10: mode_q <= ModeProgSetup;
`ifdef G18_RESP_LOCK_EN
              8'h60: mode_q <= ModeLockSetup;
`endif
              default: ;
            endcase
          end
        end
        ModeProgSetup: begin
          if (wr_strobe) begin
            prog_adr_q <= wr_adr_q;
            prog_dat_q <= wr_dat_q;
`ifdef G18_RESP_LOCK_EN
            if (lock_q[wr_adr_q[MEM_AW-1:6]]) begin
              status_q[4] <= 1'b1;
              status_q[1] <= 1'b1;
              mode_q      <= ModeStatus;
            end else begin
              status_q[7] <= 1'b0;
              busy_q      <= 1'b1;
              prog_cnt_q  <= '0;
              mode_q      <= ModeProgBusy;
            end
`else
            status_q[7] <= 1'b0;
            busy_q      <= 1'b1;
            prog_cnt_q  <= '0;
            mode_q      <= ModeProgBusy;
`endif
          end
        end
        ModeProgBusy: begin
          if (prog_last) begin
            if (prog_new != prog_dat_q) status_q[4] <= 1'b1;
            status_q[7] <= 1'b1;
            busy_q      <= 1'b0;
            mode_q      <= ModeStatus;
          end else begin
            prog_cnt_q <= prog_cnt_q + 8'd1;
          end
        end
`ifdef G18_RESP_LOCK_EN
        ModeLockSetup: begin
          if (wr_strobe) begin
            case (cmd)
              8'h01: lock_q[wr_adr_q[MEM_AW-1:6]] <= 1'b1;
              8'hD0: lock_q[wr_adr_q[MEM_AW-1:6]] <= 1'b0;
              default: begin
                status_q[5] <= 1'b1;
                status_q[4] <= 1'b1;
              end
            endcase
            mode_q <= ModeStatus;
          end
        end
`endif
        default: mode_q <= ModeArray;
      endcase
    end
  end

  // Word presented to the bus for the current mode and address.
  always_comb begin
    rd_word = {8'h00, status_q};
    case (mode_q)
      ModeArray:  rd_word = ram_word;
      ModeStatus: rd_word = {8'h00, status_q};
      ModeId: begin
        if (eff_adr == '0) begin
          rd_word = MFR_ID;
        end else if (eff_adr == MEM_AW'(1)) begin
          rd_word = DEV_ID;
`ifdef G18_RESP_LOCK_EN
        end else if (eff_adr[5:0] == 6'd2) begin
          rd_word = {15'b0, lock_q[eff_adr[MEM_AW-1:6]]};
`endif
        end else begin
          rd_word = 16'h0000;
        end
      end
      default:    rd_word = {8'h00, status_q};
    endcase
  end

  // Read latency counter; an address change inside a read counts as a fresh first cycle.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (!read_act) begin
      rd_cnt_d = '0;
    end else if ((rd_cnt_q != '0) && (eff_adr != rd_adr_q)) begin
      rd_cnt_d = 4'd1;
    end else if (rd_cnt_q != 4'hF) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
    end
    dat_d = (read_act && (rd_cnt_d >= 4'(READ_LAT))) ? rd_word : 16'h0000;
  end

  // Registered read data and driver enable.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      rd_cnt_q <= '0;
      rd_adr_q <= '0;
      dat_q    <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      rd_adr_q <= eff_adr;
      dat_q    <= dat_d;
      dat_oe_q <= read_act;
    end
  end

  assign g18_dat_o    = dat_q;
  assign g18_dat_oe_o = dat_oe_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_g18_flash_responder.sv
// Bench for g18_flash_responder: directed test-plan sequences with literal expectations,
// then randomized bus activity checked every cycle against a behavioural model.
module tb_g18_flash_responder;

  localparam int unsigned ReadLat    = 3;
  localparam int unsigned ProgCycles = 16;

  localparam int MArray = 0, MStatus = 1, MId = 2, MSetup = 3, MBusy = 4, MLock = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] adr;
  logic        csn, oen, wen, advn;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        dat_oe;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  g18_flash_responder #(
    .MEM_AW     (12),
    .READ_LAT   (ReadLat),
    .PROG_CYCLES(ProgCycles),
    .MFR_ID     (16'h0089),
    .DEV_ID     (16'h8960)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .g18_adr_i   (adr),
    .g18_csn_i   (csn),
    .g18_oen_i   (oen),
    .g18_wen_i   (wen),
    .g18_advn_i  (advn),
    .g18_dat_i   (dat_i),
    .g18_dat_o   (dat_o),
    .g18_dat_oe_o(dat_oe),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [4096];
  int          m_mode;
  logic [7:0]  m_status;
  logic [11:0] m_lat, m_padr, m_tgt, m_prd, m_eff;
  logic        m_pwen, m_ra, m_strobe;
  logic [15:0] m_pdat, m_tdat;
  logic [7:0]  m_cmd;
  int          m_left, m_run;
  logic [63:0] m_lock;
  logic [15:0] exp_dat;
  logic        exp_oe, exp_busy;
  bit          live = 0;

  initial for (int i = 0; i < 4096; i++) m_mem[i] = 16'hFFFF;

  function automatic logic [15:0] m_word(input logic [11:0] a);
    case (m_mode)
      MArray:  return m_mem[a];
      MStatus: return {8'h00, m_status};
      MId: begin
        if (a == 12'd0) return 16'h0089;
        if (a == 12'd1) return 16'h8960;
`ifdef G18_RESP_LOCK_EN
        if (a[5:0] == 6'd2) return {15'b0, m_lock[a[11:6]]};
`endif
        return 16'h0000;
      end
      default: return {8'h00, m_status};
    endcase
  endfunction

  // Model step on each rising edge, then compare the DUT just after the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = MArray; m_status = 8'h80; m_lat = '0; m_pwen = 1'b1; m_pdat = '0;
      m_padr = '0; m_run = 0; m_prd = '0; m_left = 0; m_lock = '1;
      exp_dat = '0; exp_oe = 1'b0; exp_busy = 1'b0;
      live = 1;
    end else begin
      m_eff = (!csn && !advn) ? adr[11:0] : m_lat;
      m_ra  = !csn && !oen && wen;
      if (!m_ra) m_run = 0;
      else if (m_run > 0 && m_eff != m_prd) m_run = 1;
      else if (m_run < 15) m_run++;
      exp_dat = (m_ra && m_run >= ReadLat) ? m_word(m_eff) : 16'h0000;
      exp_oe  = m_ra;
      m_prd   = m_eff;
      m_strobe = !csn && !m_pwen && wen;
      m_cmd    = m_pdat[7:0];
      case (m_mode)
        MBusy: begin
          m_left--;
          if (m_left == 0) begin
            if ((m_mem[m_tgt] & m_tdat) != m_tdat) m_status[4] = 1'b1;
            m_mem[m_tgt] = m_mem[m_tgt] & m_tdat;
            m_status[7] = 1'b1;
            m_mode = MStatus;
          end
        end
        MSetup: if (m_strobe) begin
          m_tgt = m_padr; m_tdat = m_pdat;
`ifdef G18_RESP_LOCK_EN
          if (m_lock[m_padr[11:6]]) begin
            m_status = m_status | 8'h12;
            m_mode = MStatus;
          end else begin
            m_mode = MBusy; m_left = ProgCycles; m_status[7] = 1'b0;
          end
`else
          m_mode = MBusy; m_left = ProgCycles; m_status[7] = 1'b0;
`endif
        end
        MLock: if (m_strobe) begin
          if (m_cmd == 8'h01) m_lock[m_padr[11:6]] = 1'b1;
          else if (m_cmd == 8'hD0) m_lock[m_padr[11:6]] = 1'b0;
          else m_status = m_status | 8'h30;
          m_mode = MStatus;
        end
        default: if (m_strobe) begin
          case (m_cmd)
            8'hFF: m_mode = MArray;
            8'h70: m_mode = MStatus;
            8'h90: m_mode = MId;
            8'h50: m_status = m_status & 8'hED;
            8'h40, 8'h10: m_mode = MSetup;
`ifdef G18_RESP_LOCK_EN
            8'h60: m_mode = MLock;
`endif
            default: ;
          endcase
        end
      endcase
      exp_busy = (m_mode == MBusy);
      m_pwen = wen; m_pdat = dat_i; m_padr = m_eff;
      if (!csn && !advn) m_lat = adr[11:0];
    end
    #1;
    if (live) begin
      chk("cyc_dat_o", dat_o, exp_dat);
      chk("cyc_dat_oe", {15'b0, dat_oe}, {15'b0, exp_oe});
      chk("cyc_busy", {15'b0, busy}, {15'b0, exp_busy});
    end
  end

  // ---------------- stimulus helpers (start and end on a falling edge) ----------------
  task automatic bus_idle();
    csn = 1'b1; oen = 1'b1; wen = 1'b1; advn = 1'b1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d);
    csn = 1'b0; advn = 1'b0; oen = 1'b1; adr = a; dat_i = d; wen = 1'b0;
    @(negedge clk);
    wen = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd_word(input logic [24:0] a, output logic [15:0] v);
    csn = 1'b0; advn = 1'b0; oen = 1'b0; wen = 1'b1; adr = a;
    repeat (ReadLat) @(posedge clk);
    @(negedge clk);
    v = dat_o;
    bus_idle();
  endtask

  task automatic prog(input logic [24:0] a, input logic [15:0] d, output int n);
    wr(a, 16'h0040);
    wr(a, d);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [15:0] v;
  int          n;
  logic [7:0]  cmd_tab [10];

  initial begin
    cmd_tab = '{8'hFF, 8'h70, 8'h90, 8'h50, 8'h40, 8'h10, 8'h60, 8'h01, 8'hD0, 8'h00};
    rst_n = 1'b0; adr = '0; dat_i = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dat_o", dat_o, 16'h0000);
    chk("rst_dat_oe", {15'b0, dat_oe}, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);

    rd_word(25'd5, v);            chk("erased_read", v, 16'hFFFF);

    prog(25'd7, 16'h1234, n);     chk("busy_cycles", 16'(n), 16'd16);
    rd_word(25'd0, v);            chk("status_after_prog", v, 16'h0080);
    wr(25'd0, 16'h00FF);
    rd_word(25'd7, v);            chk("prog_read", v, 16'h1234);

    prog(25'd7, 16'h00FF, n);
    rd_word(25'd0, v);            chk("status_prog_err", v, 16'h0090);
    wr(25'd0, 16'h00FF);
    rd_word(25'd7, v);            chk("and_program", v, 16'h0034);
    wr(25'd0, 16'h0070);
    wr(25'd0, 16'h0050);
    rd_word(25'd0, v);            chk("status_cleared", v, 16'h0080);

    wr(25'd0, 16'h0090);
    rd_word(25'd0, v);            chk("mfr_id", v, 16'h0089);
    rd_word(25'd1, v);            chk("dev_id", v, 16'h8960);
    rd_word(25'd3, v);            chk("id_other", v, 16'h0000);
    wr(25'd0, 16'h00FF);
    rd_word(25'd7 + 25'd4096, v); chk("alias_read", v, 16'h0034);

    // Reset during the fifth busy cycle.
    wr(25'd9, 16'h0040);
    wr(25'd9, 16'h0000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {15'b0, busy}, 16'h0000);
    rst_n = 1'b1;
    rd_word(25'd9, v);            chk("abort_word", v, 16'hFFFF);

`ifdef G18_RESP_LOCK_EN
    prog(25'd100, 16'h0F0F, n);   chk("locked_no_busy", 16'(n), 16'd0);
    rd_word(25'd100, v);          chk("locked_status", v, 16'h0092);
    wr(25'd0, 16'h0050);
    wr(25'd100, 16'h0060);
    wr(25'd100, 16'h00D0);
    prog(25'd100, 16'h0F0F, n);   chk("unlocked_busy", 16'(n), 16'd16);
    rd_word(25'd0, v);            chk("unlocked_status", v, 16'h0080);
    wr(25'd0, 16'h0090);
    rd_word(25'd2, v);            chk("lock_bit_set", v, 16'h0001);
    rd_word(25'd66, v);           chk("lock_bit_clr", v, 16'h0000);
    wr(25'd0, 16'h00FF);
    rd_word(25'd100, v);          chk("unlocked_word", v, 16'h0F0F);
`endif

    // Randomized bus activity; each vector holds for a few cycles.
    for (int k = 0; k < 2500; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      csn   = ($urandom_range(0, 5) == 0);
      oen   = $urandom_range(0, 1) == 1;
      wen   = $urandom_range(0, 2) != 0;
      advn  = $urandom_range(0, 3) == 0;
      adr   = {(($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'd0),
               6'($urandom_range(0, 1)), 6'($urandom_range(0, 7))};
      dat_i = {8'($urandom), ($urandom_range(0, 2) != 0) ? cmd_tab[$urandom_range(0, 9)]
                                                         : 8'($urandom)};
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    rst_n = 1'b1;
    bus_idle();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
